// File: rtl/alu_pkg.sv
// Shared widths, issue-FSM state type and result-entry sizing for the ALU issue stage.
// ALU_OVERFLOW_EN adds one overflow bit to every result entry.
package alu_pkg;

    localparam int ALU_W_IN  = 8;
    localparam int ALU_W_SEL = 3;
    localparam int ALU_W_OUT = 16;

`ifdef ALU_OVERFLOW_EN
    localparam int OVF_BITS = 1;
`else
    localparam int OVF_BITS = 0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } issue_state_t;

    typedef struct packed {
        logic [ALU_W_SEL-1:0] sel;
`ifdef ALU_OVERFLOW_EN
        logic                 ovf;
`endif
        logic [ALU_W_OUT-1:0] z;
    } res_entry_t;

    // Entry layout is {sel, [ovf,] z}; width for non-default sel/z widths.
    function automatic int entry_width(input int w_sel, input int w_out);
        return w_sel + OVF_BITS + w_out;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous result FIFO with occupancy count; push is ignored when full, pop when empty.
module alu_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; validity is tracked by count alone, keeping the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for a combinational ALU: registers x/y/sel, waits SETTLE_CYCLES, queues {sel, z}.
// Define ALU_OVERFLOW_EN to carry the ALU overflow flag alongside each result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int W_IN          = ALU_W_IN,
    parameter int W_SEL         = ALU_W_SEL,
    parameter int W_OUT         = ALU_W_OUT,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W_IN-1:0]  cmd_x,
    input  logic [W_IN-1:0]  cmd_y,
    input  logic [W_SEL-1:0] cmd_sel,
    output logic [W_IN-1:0]  alu_x,
    output logic [W_IN-1:0]  alu_y,
    output logic [W_SEL-1:0] alu_sel,
    input  logic [W_OUT-1:0] alu_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W_OUT-1:0] res_z,
    output logic [W_SEL-1:0] res_sel,
    output logic             busy,
`ifdef ALU_OVERFLOW_EN
    input  logic             alu_ovf,
    output logic             res_ovf,
`endif
    output logic [15:0]      op_count
);

    localparam int ENTRY_W = entry_width(W_SEL, W_OUT);
    localparam int CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

    issue_state_t        state;
    issue_state_t        state_nxt;
    logic [CNT_W-1:0]    settle_cnt;
    logic                accept;
    logic                push;
    logic [ENTRY_W-1:0]  push_data;
    logic [ENTRY_W-1:0]  pop_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FCW-1:0]      fifo_count;

    assign cmd_ready = (state == IDLE) && !fifo_full;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = EXEC;
            EXEC: begin
                if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands only change on accept, so the ALU inputs stay quiet while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_x      <= '0;
            alu_y      <= '0;
            alu_sel    <= '0;
            settle_cnt <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                alu_x      <= cmd_x;
                alu_y      <= cmd_y;
                alu_sel    <= cmd_sel;
                settle_cnt <= '0;
            end else if (state == EXEC) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            if (push) op_count <= op_count + 16'd1;
        end
    end

`ifdef ALU_OVERFLOW_EN
    assign push_data = {alu_sel, alu_ovf, alu_z};
    assign res_ovf   = !fifo_empty && pop_data[W_OUT];
`else
    assign push_data = {alu_sel, alu_z};
`endif

    alu_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (res_ready),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign res_valid = !fifo_empty;
    assign res_sel   = pop_data[ENTRY_W-1 -: W_SEL];
    assign res_z     = pop_data[W_OUT-1:0];

    // Acceptance is gated on full, so a sample edge must always find room.
    push_has_room: assert property (@(posedge clk) disable iff (rst)
        push |-> (fifo_count < FCW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: queue-based result model plus directed scenarios.
// Builds with or without ALU_OVERFLOW_EN.
module tb_alu_issue_ctrl;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    typedef struct packed {
        logic [2:0]  sel;
        logic        ovf;
        logic [15:0] z;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (SETTLE_CYCLES = 1) ----------------
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = '0, cmd_y = '0;
    logic [2:0]  cmd_sel = '0;
    logic [7:0]  alu_x, alu_y;
    logic [2:0]  alu_sel;
    logic [15:0] alu_z;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_z;
    logic [2:0]  res_sel;
    logic        busy;
    logic [15:0] op_count;
    logic        ovf_en = 1'b0;
`ifdef ALU_OVERFLOW_EN
    logic        alu_ovf;
    logic        res_ovf;
    assign alu_ovf = ovf_en && (alu_sel == 3'd2);
`endif

    assign alu_z = {alu_x, alu_y} ^ {13'b0, alu_sel};

    alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_sel   (cmd_sel),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_sel   (alu_sel),
        .alu_z     (alu_z),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_z     (res_z),
        .res_sel   (res_sel),
        .busy      (busy),
`ifdef ALU_OVERFLOW_EN
        .alu_ovf   (alu_ovf),
        .res_ovf   (res_ovf),
`endif
        .op_count  (op_count)
    );

    // ---------------- second DUT (SETTLE_CYCLES = 3) ----------------
    logic        rst3 = 1'b1;
    logic        cmd_valid3 = 1'b0;
    logic        cmd_ready3;
    logic [7:0]  cmd_x3 = '0, cmd_y3 = '0;
    logic [2:0]  cmd_sel3 = '0;
    logic [7:0]  alu_x3, alu_y3;
    logic [2:0]  alu_sel3;
    logic [15:0] alu_z3;
    logic        res_valid3;
    logic [15:0] res_z3;
    logic [2:0]  res_sel3;
    logic        busy3;
    logic [15:0] op_count3;
`ifdef ALU_OVERFLOW_EN
    logic        res_ovf3;
`endif

    assign alu_z3 = {alu_x3, alu_y3} ^ {13'b0, alu_sel3};

    alu_issue_ctrl #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(3)) dut3 (
        .clk       (clk),
        .rst       (rst3),
        .cmd_valid (cmd_valid3),
        .cmd_ready (cmd_ready3),
        .cmd_x     (cmd_x3),
        .cmd_y     (cmd_y3),
        .cmd_sel   (cmd_sel3),
        .alu_x     (alu_x3),
        .alu_y     (alu_y3),
        .alu_sel   (alu_sel3),
        .alu_z     (alu_z3),
        .res_valid (res_valid3),
        .res_ready (1'b0),
        .res_z     (res_z3),
        .res_sel   (res_sel3),
        .busy      (busy3),
`ifdef ALU_OVERFLOW_EN
        .alu_ovf   (1'b0),
        .res_ovf   (res_ovf3),
`endif
        .op_count  (op_count3)
    );

    // ---------------- reference model ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    exp_t        q[$];          // results the DUT should be holding, head first
    exp_t        got[$];        // results observed leaving the DUT while recording
    logic        record   = 1'b0;
    logic        accepted = 1'b0;
    int          m_left   = 0;  // cycles until the in-flight op lands in the FIFO
    exp_t        m_cur;
    logic [7:0]  m_x = '0, m_y = '0;
    logic [2:0]  m_sel = '0;
    logic [15:0] m_cnt = '0;

    function automatic exp_t predict(input logic [7:0] x, input logic [7:0] y,
                                     input logic [2:0] sel);
        exp_t e;
        int   v;
        v     = (int'(x) * 256 + int'(y)) ^ int'(sel);
        e.z   = 16'(v);
        e.sel = sel;
        e.ovf = ovf_en && (sel == 3'd2);
        return e;
    endfunction

    // Compare every output with the model, then advance model and clock by one edge.
    task automatic cycle();
        logic m_ready;
        logic ovf_obs;
        m_ready = (m_left == 0) && (q.size() < DEPTH);
`ifdef ALU_OVERFLOW_EN
        ovf_obs = res_ovf;
`else
        ovf_obs = 1'b0;
`endif
        n_tests++;
        if (cmd_ready !== m_ready) begin
            n_fail++;
            $display("FAIL cmd_ready @%0d: got %b expected %b", cyc, cmd_ready, m_ready);
        end
        n_tests++;
        if (busy !== (m_left != 0)) begin
            n_fail++;
            $display("FAIL busy @%0d: got %b expected %b", cyc, busy, m_left != 0);
        end
        n_tests++;
        if (res_valid !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL res_valid @%0d: got %b expected %b", cyc, res_valid, q.size() != 0);
        end
        if (q.size() != 0) begin
            n_tests++;
            if (res_z !== q[0].z || res_sel !== q[0].sel || ovf_obs !== q[0].ovf) begin
                n_fail++;
                $display("FAIL head @%0d: got z=%h sel=%0d ovf=%b expected z=%h sel=%0d ovf=%b",
                         cyc, res_z, res_sel, ovf_obs, q[0].z, q[0].sel, q[0].ovf);
            end
        end else begin
            n_tests++;
            if (ovf_obs !== 1'b0) begin
                n_fail++;
                $display("FAIL res_ovf_empty @%0d: got %b expected 0", cyc, ovf_obs);
            end
        end
        n_tests++;
        if (op_count !== m_cnt) begin
            n_fail++;
            $display("FAIL op_count @%0d: got %0d expected %0d", cyc, op_count, m_cnt);
        end
        n_tests++;
        if (alu_x !== m_x || alu_y !== m_y || alu_sel !== m_sel) begin
            n_fail++;
            $display("FAIL alu_regs @%0d: got %h/%h/%0d expected %h/%h/%0d",
                     cyc, alu_x, alu_y, alu_sel, m_x, m_y, m_sel);
        end

        if (record && res_valid && res_ready) got.push_back('{sel: res_sel, ovf: ovf_obs, z: res_z});
        accepted = !rst && cmd_valid && m_ready;

        if (rst) begin
            q.delete();
            m_left = 0;
            m_x = '0; m_y = '0; m_sel = '0;
            m_cnt = '0;
        end else begin
            if (res_ready && q.size() != 0) void'(q.pop_front());
            if (m_left == 1) begin
                q.push_back(m_cur);
                m_cnt++;
            end
            if (m_left > 0) m_left--;
            if (accepted) begin
                m_left = SETTLE;
                m_cur  = predict(cmd_x, cmd_y, cmd_sel);
                m_x = cmd_x; m_y = cmd_y; m_sel = cmd_sel;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [2:0] sel);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_x = x; cmd_y = y; cmd_sel = sel;
        accepted = 1'b0;
        while (!accepted && n < 40) begin
            cycle();
            n++;
        end
        cmd_valid = 1'b0;
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: cmd %h/%h/%0d not accepted in %0d cycles", x, y, sel, n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_x = 8'h5A; cmd_y = 8'hA5; cmd_sel = 3'd6;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        rst = 1'b0;
        n_tests++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || op_count !== 16'd0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b busy=%b cnt=%0d ready=%b expected 0/0/0/1",
                     res_valid, busy, op_count, cmd_ready);
        end
        n_tests++;
        if (alu_x !== 8'h00 || alu_y !== 8'h00 || alu_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_alu_regs: got %h/%h/%0d expected 0/0/0", alu_x, alu_y, alu_sel);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int start;
        res_ready = 1'b1;
        got.delete();
        record = 1'b1;
        start = cyc;
        for (int s = 0; s < 8; s++) issue(8'hAF, 8'hF0, 3'(s));
        n_tests++;
        if (cyc - start !== 15) begin
            n_fail++;
            $display("FAIL b2b_throughput: got %0d cycles expected 15", cyc - start);
        end
        idle(4);
        record = 1'b0;
        n_tests++;
        if (got.size() !== 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results expected 8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_tests++;
            if (got[i].z !== 16'hAFF0 + 16'(i) || got[i].sel !== 3'(i)) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: got z=%h sel=%0d expected z=%h sel=%0d",
                         i, got[i].z, got[i].sel, 16'hAFF0 + 16'(i), i);
            end
        end
    endtask

    task automatic test_fifo_full();
        int wait_n;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(8'($urandom), 8'($urandom), 3'($urandom));
        cycle();
        n_tests++;
        if (cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ready: got ready=%b valid=%b expected 0/1", cmd_ready, res_valid);
        end
        cmd_valid = 1'b1;
        cmd_x = 8'h3C; cmd_y = 8'hC3; cmd_sel = 3'd4;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_tests++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL full_blocked: got busy=%b expected 0 while full", busy);
            end
        end
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        wait_n = 0;
        accepted = 1'b0;
        while (!accepted && wait_n < 10) begin
            cycle();
            wait_n++;
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (wait_n !== 1) begin
            n_fail++;
            $display("FAIL full_fifth_accept: got accept after %0d cycles expected 1", wait_n);
        end
        res_ready = 1'b1;
        idle(8);
    endtask

    task automatic test_push_pop_same_edge();
        exp_t issued[$];
        logic [7:0] x, y;
        logic [2:0] s;
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = 8'($urandom); y = 8'($urandom); s = 3'($urandom);
            issued.push_back(predict(x, y, s));
            if (i == 3) begin
                issue(x, y, s);
                res_ready = 1'b1;   // pop on the same edge as this op's push
                cycle();
                res_ready = 1'b0;
                n_tests++;
                if (cmd_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pushpop_count: got ready=%b expected 1 (3 entries)", cmd_ready);
                end
            end else begin
                issue(x, y, s);
            end
        end
        cycle();
        n_tests++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_refill: got ready=%b expected 0 (4 entries)", cmd_ready);
        end
        got.delete();
        record = 1'b1;
        res_ready = 1'b1;
        idle(6);
        record = 1'b0;
        n_tests++;
        if (got.size() !== 4) begin
            n_fail++;
            $display("FAIL pushpop_drain: got %0d results expected 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_tests++;
            if (got[i].z !== issued[i+1].z || got[i].sel !== issued[i+1].sel) begin
                n_fail++;
                $display("FAIL pushpop_order[%0d]: got %h/%0d expected %h/%0d",
                         i, got[i].z, got[i].sel, issued[i+1].z, issued[i+1].sel);
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        res_ready = 1'b0;
        issue(8'h11, 8'h22, 3'd1);
        issue(8'h33, 8'h44, 3'd2);
        issue(8'h55, 8'h66, 3'd3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_tests++;
        if (res_valid !== 1'b0 || op_count !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midexec_reset: got valid=%b cnt=%0d busy=%b expected 0/0/0",
                     res_valid, op_count, busy);
        end
        n_tests++;
        if (alu_x !== 8'h00 || alu_y !== 8'h00 || alu_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL midexec_alu_regs: got %h/%h/%0d expected 0/0/0", alu_x, alu_y, alu_sel);
        end
        idle(3);
        n_tests++;
        if (res_valid !== 1'b0 || op_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midexec_late_push: got valid=%b cnt=%0d expected 0/0", res_valid, op_count);
        end
    endtask

    task automatic test_overflow();
`ifdef ALU_OVERFLOW_EN
        ovf_en = 1'b1;
        res_ready = 1'b0;
        for (int s = 0; s < 4; s++) issue(8'($urandom), 8'($urandom), 3'(s));
        cycle();
        got.delete();
        record = 1'b1;
        res_ready = 1'b1;
        idle(5);
        record = 1'b0;
        ovf_en = 1'b0;
        n_tests++;
        if (got.size() !== 4) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d results expected 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_tests++;
            if (got[i].ovf !== (i == 2)) begin
                n_fail++;
                $display("FAIL ovf_flag[%0d]: got %b expected %b", i, got[i].ovf, i == 2);
            end
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 3) != 0);
            cmd_x     = 8'($urandom);
            cmd_y     = 8'($urandom);
            cmd_sel   = 3'($urandom);
            res_ready = ($urandom_range(0, 9) < 6);
            ovf_en    = 1'b0;
            rst       = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        idle(6);
    endtask

    task automatic test_settle3();
        int edges;
        int busy_cycles;
        rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b0;
        cmd_valid3 = 1'b1;
        cmd_x3 = 8'h12; cmd_y3 = 8'h34; cmd_sel3 = 3'd5;
        n_tests++;
        if (cmd_ready3 !== 1'b1 || busy3 !== 1'b0) begin
            n_fail++;
            $display("FAIL settle3_idle: got ready=%b busy=%b expected 1/0", cmd_ready3, busy3);
        end
        @(posedge clk);          // accept edge
        #1;
        cmd_valid3 = 1'b0;
        edges = 0;
        busy_cycles = 0;
        while (!res_valid3 && edges < 12) begin
            if (busy3) busy_cycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        n_tests++;
        if (edges !== 3) begin
            n_fail++;
            $display("FAIL settle3_latency: got res_valid %0d edges after accept expected 3", edges);
        end
        n_tests++;
        if (busy_cycles !== 3) begin
            n_fail++;
            $display("FAIL settle3_busy: got %0d busy cycles expected 3", busy_cycles);
        end
        n_tests++;
        if (res_z3 !== 16'h1231 || res_sel3 !== 3'd5 || op_count3 !== 16'd1) begin
            n_fail++;
            $display("FAIL settle3_result: got z=%h sel=%0d cnt=%0d expected 1231/5/1",
                     res_z3, res_sel3, op_count3);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fifo_full();
        test_push_pop_same_edge();
        test_reset_mid_exec();
        test_overflow();
        test_random();
        test_settle3();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
